// File: rtl/character_registers.sv
// Position registers for Pacman (index 0) and four ghosts (indices 1-4), with a combinational lookup port for the display.
// Lookup is zero-latency. A move request accepted at edge E commits char i at edge E+1+i. move_done pulses after E+5.
// move_ready is high only in IDLE. Requests seen while busy are dropped, not queued.
module character_registers #(
  parameter int X_MAX = 99,
  parameter int Y_MAX = 114,
  parameter int STEP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  char_sel,
  output logic [7:0]  char_x,
  output logic [7:0]  char_y,
  output logic        pac_orient,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [14:0] move_dir,
  output logic        move_done
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  localparam logic [8:0] XMAX9 = 9'(X_MAX);
  localparam logic [8:0] YMAX9 = 9'(Y_MAX);
  localparam logic [8:0] STEP9 = 9'(STEP);

  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [7:0] RST_X [5] = '{8'd48, 8'd48, 8'd44, 8'd48, 8'd52};
  localparam logic [7:0] RST_Y [5] = '{8'd84, 8'd44, 8'd54, 8'd54, 8'd54};

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [14:0] dir_q, dir_d;
  logic [7:0]  x_q [5];
  logic [7:0]  x_d [5];
  logic [7:0]  y_q [5];
  logic [7:0]  y_d [5];
  logic        orient_q, orient_d;

  logic [2:0]  cur_dir;
  logic [8:0]  cur_x, cur_y;
  logic [7:0]  new_x, new_y;

  // Select the character being committed this cycle and its latched direction.
  always_comb begin
    cur_x   = '0;
    cur_y   = '0;
    cur_dir = 3'd0;
    if (idx_q < 3'd5) begin
      cur_x = {1'b0, x_q[idx_q]};
      cur_y = {1'b0, y_q[idx_q]};
    end
    case (idx_q)
      3'd0:    cur_dir = dir_q[2:0];
      3'd1:    cur_dir = dir_q[5:3];
      3'd2:    cur_dir = dir_q[8:6];
      3'd3:    cur_dir = dir_q[11:9];
      3'd4:    cur_dir = dir_q[14:12];
      default: cur_dir = 3'd0;
    endcase
  end

  // One step of movement. y clamps to [0, Y_MAX]. x wraps through the tunnel.
  always_comb begin
    new_x = cur_x[7:0];
    new_y = cur_y[7:0];
    case (cur_dir)
      DIR_UP:    new_y = (cur_y < STEP9) ? 8'd0 : 8'(cur_y - STEP9);
      DIR_DOWN:  new_y = (cur_y + STEP9 > YMAX9) ? YMAX9[7:0] : 8'(cur_y + STEP9);
      DIR_LEFT:  new_x = (cur_x < STEP9) ? 8'(cur_x + XMAX9 + 9'd1 - STEP9)
                                         : 8'(cur_x - STEP9);
      DIR_RIGHT: new_x = (cur_x + STEP9 > XMAX9) ? 8'(cur_x + STEP9 - (XMAX9 + 9'd1))
                                                 : 8'(cur_x + STEP9);
      default:   ;
    endcase
  end

  // Handshake FSM: latch the request, commit one character per cycle, then pulse done.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    x_d        = x_q;
    y_d        = y_q;
    orient_d   = orient_q;
    move_ready = 1'b0;
    move_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        move_ready = 1'b1;
        if (move_valid) begin
          dir_d   = move_dir;
          idx_d   = 3'd0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (idx_q < 3'd5) begin
          x_d[idx_q] = new_x;
          y_d[idx_q] = new_y;
        end
        // Only Pacman's horizontal moves change facing.
        if (idx_q == 3'd0) begin
          if (cur_dir == DIR_LEFT)  orient_d = 1'b0;
          if (cur_dir == DIR_RIGHT) orient_d = 1'b1;
        end
        if (idx_q == 3'd4) state_d = S_DONE;
        else               idx_d   = idx_q + 3'd1;
      end
      S_DONE: begin
        move_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset wins over any concurrent request and discards partial updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      dir_q    <= '0;
      x_q      <= RST_X;
      y_q      <= RST_Y;
      orient_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      orient_q <= orient_d;
    end
  end

  // Display lookup. Unused indices read as origin.
  always_comb begin
    char_x = '0;
    char_y = '0;
    if (char_sel < 3'd5) begin
      char_x = x_q[char_sel];
      char_y = y_q[char_sel];
    end
  end

  assign pac_orient = orient_q;

endmodule

// File: tb/tb_character_registers.sv
// Testbench for character_registers: directed scenarios plus random moves checked against a position model.
// Inputs are driven and outputs sampled on the falling edge, well clear of the rising edge.
// Expected positions come from modular/clamped arithmetic on integer arrays.
module tb_character_registers;

  localparam int X_MAX = 99;
  localparam int Y_MAX = 114;
  localparam int STEP  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  char_sel;
  logic [7:0]  char_x, char_y;
  logic        pac_orient;
  logic        move_valid;
  logic        move_ready;
  logic [14:0] move_dir;
  logic        move_done;

  int checks = 0;
  int errors = 0;
  int mx [5];
  int my [5];
  int mor;

  character_registers #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_sel   (char_sel),
    .char_x     (char_x),
    .char_y     (char_y),
    .pac_orient (pac_orient),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_dir   (move_dir),
    .move_done  (move_done)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mx  = '{48, 48, 44, 48, 52};
    my  = '{84, 44, 54, 54, 54};
    mor = 0;
  endfunction

  // Apply one step to character i from code d.
  function automatic void model_step(input int i, input int d);
    case (d)
      1: begin my[i] = my[i] - STEP; if (my[i] < 0) my[i] = 0; end
      2: begin my[i] = my[i] + STEP; if (my[i] > Y_MAX) my[i] = Y_MAX; end
      3: mx[i] = (mx[i] - STEP + X_MAX + 1) % (X_MAX + 1);
      4: mx[i] = (mx[i] + STEP) % (X_MAX + 1);
      default: ;
    endcase
    if (i == 0 && d == 3) mor = 0;
    if (i == 0 && d == 4) mor = 1;
  endfunction

  task automatic check_char(input int k);
    char_sel = k[2:0];
    #1;
    if (k < 5) begin
      check($sformatf("x[%0d]", k), char_x, mx[k]);
      check($sformatf("y[%0d]", k), char_y, my[k]);
    end else begin
      check($sformatf("x[%0d]", k), char_x, 0);
      check($sformatf("y[%0d]", k), char_y, 0);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 8; k++) check_char(k);
    check("orient", pac_orient, mor);
    check("ready_idle", move_ready, 1);
    check("done_idle", move_done, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset      = 1'b1;
    move_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One full move cycle. With hold set, move_valid stays high and move_dir churns while busy.
  task automatic do_move(input logic [14:0] dir, input bit hold);
    int d;
    d = int'(dir);
    @(negedge clk);
    check("ready_before", move_ready, 1);
    move_valid = 1'b1;
    move_dir   = dir;
    @(negedge clk);
    if (!hold) move_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (hold) move_dir = 15'($urandom);
      @(negedge clk);
      model_step(k, (d >> (3 * k)) & 7);
      check("ready_busy", move_ready, 0);
      check("done_timing", move_done, (k == 4) ? 1 : 0);
      check_char(k);
      if (k < 4) check_char(k + 1);
      if (k == 0) check("orient_commit", pac_orient, mor);
    end
    if (hold) move_dir = 15'($urandom);
    @(negedge clk);
    check("ready_after", move_ready, 1);
    check("done_after", move_done, 0);
    move_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    move_valid = 1'b0;
    move_dir   = '0;
    char_sel   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all();

    // Everyone right.
    do_move(15'h4924, 1'b0);
    check_char(0);
    check("char0_x_right", char_x, 49);
    check_char(4);
    check("char4_x_right", char_x, 53);
    check("orient_right", pac_orient, 1);

    // Tunnel wrap on Pacman.
    apply_reset();
    for (int n = 0; n < 48; n++) do_move(15'h0003, 1'b0);
    check_char(0);
    check("tunnel_x0", char_x, 0);
    do_move(15'h0003, 1'b0);
    check_char(0);
    check("tunnel_wrap_left", char_x, 99);
    do_move(15'h0004, 1'b0);
    check_char(0);
    check("tunnel_wrap_right", char_x, 0);

    // Clamp at the top for ghost 1.
    for (int n = 0; n < 44; n++) do_move(15'h0008, 1'b0);
    check_char(1);
    check("clamp_y0", char_y, 0);
    do_move(15'h0008, 1'b0);
    check_char(1);
    check("clamp_stay", char_y, 0);

    // Illegal code on Pacman holds position and facing.
    do_move(15'h0006, 1'b0);
    check_char(0);
    check("illegal_x", char_x, 0);
    check("illegal_orient", pac_orient, 1);

    // valid held high through the update with churning move_dir.
    do_move(15'h4924, 1'b1);
    do_move(15'h1111, 1'b1);
    check_all();

    // Reset at edge E+3.
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = 15'h4924;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("done_pre_abort", move_done, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("no_done_after_abort", move_done, 0);
    end

    // Reset and move_valid on the same edge.
    do_move(15'h4924, 1'b0);
    @(negedge clk);
    reset      = 1'b1;
    move_valid = 1'b1;
    move_dir   = 15'h4924;
    @(negedge clk);
    reset      = 1'b0;
    move_valid = 1'b0;
    model_reset();
    check_all();
    @(negedge clk);
    check("not_accepted_ready", move_ready, 1);
    check_char(0);

    // Random moves.
    for (int n = 0; n < 60; n++) begin
      do_move(15'($urandom), 1'($urandom_range(0, 1)));
      if (n % 10 == 9) check_all();
    end
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
